// File: rtl/ccd_line_capture.sv
// TCD1500C line receiver: tracks SH/SP timing, drops the leading dummy pixels, buffers the ADC
// samples for one line, then streams it as SYNC0 SYNC1 {of,000,d[11:8]} d[7:0] ... bytes.
module ccd_line_capture #(
  parameter int          N_PIXELS   = 5340,
  parameter int          DUMMY_LEAD = 64,
  parameter int          SAMPLE_DLY = 5,
  parameter logic [7:0]  SYNC0      = 8'hA5,
  parameter logic [7:0]  SYNC1      = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        ccd_sh,
  input  logic        ccd_sp,
  input  logic [11:0] adc_d,
  input  logic        adc_of,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        line_done,
  output logic [15:0] drop_cnt
);
  localparam int PW = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
  localparam int SW = (DUMMY_LEAD > 0) ? $clog2(DUMMY_LEAD + 1) : 1;
  localparam int BW = $clog2(2 * N_PIXELS + 3);
  localparam logic [PW-1:0] LAST_PIX  = PW'(N_PIXELS - 1);
  localparam logic [SW-1:0] LAST_SKIP = SW'((DUMMY_LEAD > 0) ? DUMMY_LEAD - 1 : 0);
  localparam logic [BW-1:0] TOTAL     = BW'(2 * N_PIXELS + 2);

  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, SEND} state_t;
  state_t state_q, state_d;

  logic          sh_q, sp_q, sh_edge, sp_edge;
  logic [SW-1:0] skip_cnt;
  logic [PW-1:0] pix_cnt, rd_addr;
  logic [BW-1:0] bcnt;
  logic [12:0]   mem [N_PIXELS];
  logic [12:0]   rd_q;
  logic [7:0]    lo_byte, nxt_byte;
  logic [SAMPLE_DLY:0] vld_pipe;
  logic          wr_en, ld, last_acc;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_q <= 1'b0;
      sp_q <= 1'b0;
    end else begin
      sh_q <= ccd_sh;
      sp_q <= ccd_sp;
    end

  assign sh_edge = ccd_sh & ~sh_q;
  assign sp_edge = ccd_sp & ~sp_q;

  // SP edges ride a shift register so overlapping sample delays never swallow a pixel
  assign vld_pipe[0] = sp_edge & (state_q == CAPTURE);
  generate
    if (SAMPLE_DLY > 0) begin : g_dly
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                  vld_pipe[SAMPLE_DLY:1] <= '0;
        else if (state_q != CAPTURE) vld_pipe[SAMPLE_DLY:1] <= '0;
        else                         vld_pipe[SAMPLE_DLY:1] <= vld_pipe[SAMPLE_DLY-1:0];
    end
  endgenerate

  assign wr_en    = vld_pipe[SAMPLE_DLY] & (state_q == CAPTURE);
  assign last_acc = (state_q == SEND) & tx_valid & tx_ready & (bcnt == TOTAL);
  assign ld       = (state_q == SEND) & (~tx_valid | tx_ready) & (bcnt != TOTAL);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sh_edge && enable) state_d = (DUMMY_LEAD == 0) ? CAPTURE : SKIP;
      SKIP:    if (sp_edge && skip_cnt == LAST_SKIP) state_d = CAPTURE;
      CAPTURE: if (wr_en && pix_cnt == LAST_PIX) state_d = SEND;
      SEND:    if (last_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      skip_cnt  <= '0;
      pix_cnt   <= '0;
      drop_cnt  <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= last_acc;
      if (state_q == IDLE) begin
        skip_cnt <= '0;
        pix_cnt  <= '0;
      end else begin
        if (state_q == SKIP && sp_edge) skip_cnt <= skip_cnt + SW'(1);
        if (wr_en)                      pix_cnt  <= pix_cnt + PW'(1);
      end
      if (sh_edge && state_q != IDLE && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

  always_ff @(posedge clk) begin
    if (wr_en) mem[pix_cnt] <= {adc_of, adc_d};
    rd_q <= mem[rd_addr];
  end

  // High byte comes straight from the RAM register; low byte is parked so the read can run ahead
  always_comb begin
    nxt_byte = lo_byte;
    if (bcnt == '0)                 nxt_byte = SYNC0;
    else if (bcnt == BW'(1))        nxt_byte = SYNC1;
    else if (!bcnt[0])              nxt_byte = {rd_q[12], 3'b000, rd_q[11:8]};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      bcnt     <= '0;
      rd_addr  <= '0;
      lo_byte  <= '0;
    end else if (state_q != SEND) begin
      tx_valid <= 1'b0;
      bcnt     <= '0;
      rd_addr  <= '0;
    end else if (ld) begin
      tx_data  <= nxt_byte;
      tx_valid <= 1'b1;
      bcnt     <= bcnt + BW'(1);
      if (bcnt >= BW'(2) && !bcnt[0]) begin
        lo_byte <= rd_q[7:0];
        if (rd_addr != LAST_PIX) rd_addr <= rd_addr + PW'(1);
      end
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_ccd_line_capture.sv
// Directed + randomized bench for ccd_line_capture; expected streams come from a line-level model.
module tb_ccd_line_capture;
  localparam int NP = 4, DL = 2, SD = 2, NSP = DL + NP, NB = 2 + 2 * NP;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ccd_sh = 1'b0, ccd_sp = 1'b0;
  logic        adc_of = 1'b0, tx_ready = 1'b0;
  logic [11:0] adc_d = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, line_done;
  logic [15:0] drop_cnt;

  ccd_line_capture #(.N_PIXELS(NP), .DUMMY_LEAD(DL), .SAMPLE_DLY(SD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ccd_sh(ccd_sh), .ccd_sp(ccd_sp),
    .adc_d(adc_d), .adc_of(adc_of), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .line_done(line_done), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int rdy_mode = 0;
  int cyc = 0, done_cnt = 0, stall_viol = 0;
  logic [7:0] got_q[$];
  int         acc_cyc[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [12:0] vals [NSP];

  // consumer: always ready, toggling, or random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (line_done) done_cnt++;
    if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol++;
    if (tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      acc_cyc.push_back(cyc);
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sh_pulse();
    ccd_sh = 1'b1; tick(); tick();
    ccd_sh = 1'b0; tick(); tick();
  endtask

  task automatic sp_pixel(input logic [12:0] v);
    adc_d = v[11:0]; adc_of = v[12]; ccd_sp = 1'b1;
    repeat (3) tick();
    ccd_sp = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 400) begin
      tick();
      k++;
    end
    tick(); tick();
    check("line_done_pulses", 32'(done_cnt - d0), 1);
  endtask

  // Full line: SH, NSP sample pulses carrying vals[], optional SH during SEND, compare stream
  task automatic run_line(input string tag, input bit drop_sh, input bit gapless);
    logic [7:0] exp_q[$];
    int g0, s0, d0, k;
    g0 = got_q.size(); s0 = stall_viol; d0 = done_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < NP; i++) begin
      exp_q.push_back({vals[DL+i][12], 3'b000, vals[DL+i][11:8]});
      exp_q.push_back(vals[DL+i][7:0]);
    end
    sh_pulse();
    for (int i = 0; i < NSP; i++) sp_pixel(vals[i]);
    if (drop_sh) begin
      k = 0;
      while (!tx_valid && k < 100) begin tick(); k++; end
      check({tag, "_send_reached"}, 32'(tx_valid), 1);
      sh_pulse();
    end
    wait_done(d0);
    check({tag, "_nbytes"}, 32'(got_q.size() - g0), NB);
    for (int i = 0; i < NB; i++)
      if (g0 + i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(got_q[g0+i]), 32'(exp_q[i]));
    check({tag, "_stall_stable"}, 32'(stall_viol - s0), 0);
    check({tag, "_busy_after"}, 32'(busy), 0);
    if (gapless && got_q.size() - g0 == NB)
      check({tag, "_no_gaps"}, 32'(acc_cyc[g0+NB-1] - acc_cyc[g0]), NB - 1);
  endtask

  initial begin
    int g0, d0;
    // reset state
    repeat (3) tick();
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_line_done", 32'(line_done), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    tick();

    // basic line, always-ready consumer
    enable = 1'b1; rdy_mode = 0;
    for (int i = 0; i < NSP; i++) vals[i] = 13'(i + 1);
    run_line("basic", 1'b0, 1'b1);

    // backpressure with toggling ready
    rdy_mode = 1;
    for (int i = 0; i < NSP; i++) vals[i] = 13'($urandom);
    run_line("bp", 1'b0, 1'b0);

    // overrange bit and full sample width
    rdy_mode = 0;
    for (int i = 0; i < NSP; i++) vals[i] = {1'b0, 12'($urandom)};
    vals[DL+1] = {1'b1, 12'hABC};
    run_line("ovr", 1'b0, 1'b1);

    // SH during SEND: counted as a drop, stream unaffected, next SH starts fresh
    for (int i = 0; i < NSP; i++) vals[i] = 13'($urandom);
    run_line("drop", 1'b1, 1'b1);
    check("drop_cnt_one", 32'(drop_cnt), 1);
    for (int i = 0; i < NSP; i++) vals[i] = 13'($urandom);
    run_line("after_drop", 1'b0, 1'b1);
    check("drop_cnt_kept", 32'(drop_cnt), 1);

    // enable low: SH ignored entirely
    enable = 1'b0;
    g0 = got_q.size(); d0 = done_cnt;
    sh_pulse();
    for (int i = 0; i < NSP; i++) sp_pixel(13'($urandom));
    repeat (20) tick();
    check("dis_no_bytes", 32'(got_q.size() - g0), 0);
    check("dis_no_done", 32'(done_cnt - d0), 0);
    check("dis_busy", 32'(busy), 0);
    check("dis_drop_cnt", 32'(drop_cnt), 1);
    enable = 1'b1;

    // random lines, random consumer
    rdy_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NSP; i++) vals[i] = 13'($urandom);
      run_line($sformatf("rnd%0d", r), 1'b0, 1'b0);
    end

    // async reset in the middle of CAPTURE
    rdy_mode = 0;
    sh_pulse();
    for (int i = 0; i < DL + 1; i++) sp_pixel(13'($urandom));
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_tx_valid", 32'(tx_valid), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_drop_cnt", 32'(drop_cnt), 0);
    check("mid_rst_line_done", 32'(line_done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    g0 = got_q.size();
    for (int i = 0; i < NSP; i++) sp_pixel(13'($urandom));
    repeat (20) tick();
    check("post_rst_no_bytes", 32'(got_q.size() - g0), 0);
    check("post_rst_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
